// File: rtl/prefetch_pkg.sv
// rtl/prefetch_pkg.sv - shared prefetch types and address helper
//   prefetch_state_t : fetch FSM states
//   phys_addr()      : real-mode segment:offset to 20-bit physical address
package prefetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ABORT
    } prefetch_state_t;

    // Segment shifted by 4 plus offset; the carry out of bit 19 is dropped,
    // so addresses wrap silently at 1 MiB.
    function automatic logic [19:0] phys_addr(input logic [15:0] cs, input logic [15:0] ip);
        return {cs, 4'b0000} + {4'b0000, ip};
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - circular byte queue, 2-byte write port, 1-byte read port
//   clk, reset      : clock, asynchronous active-high reset
//   wr_en[1:0]      : bit0 pushes wr_data[7:0], bit1 pushes wr_data[15:8] (low first)
//   wr_data[15:0]   : fetched word
//   rd_en           : pop head byte (ignored when empty)
//   flush           : empty the queue; wins over pushes and pops
//   rd_data[7:0]    : head byte
//   count           : occupancy in bytes
module prefetch_fifo #(
    parameter int DEPTH = 6,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    wr_en,
    input  logic [15:0]   wr_data,
    input  logic          rd_en,
    input  logic          flush,
    output logic [7:0]    rd_data,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_W = (PW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          rd_fire;
    logic [1:0]    n_wr;

    // Pointer advance modulo DEPTH (DEPTH need not be a power of two).
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        logic [PW:0] s;
        s = {1'b0, p} + (PW + 1)'(n);
        if (s >= DEPTH_W) begin
            s = s - DEPTH_W;
        end
        return s[PW-1:0];
    endfunction

    assign rd_fire = rd_en && (count != '0);
    assign n_wr    = {1'b0, wr_en[0]} + {1'b0, wr_en[1]};
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en[0]) begin
                mem[wr_ptr] <= wr_data[7:0];
            end
            // High byte lands after the low byte when both are pushed.
            if (wr_en[1]) begin
                mem[ptr_add(wr_ptr, {1'b0, wr_en[0]})] <= wr_data[15:8];
            end
            wr_ptr <= ptr_add(wr_ptr, n_wr);
            if (rd_fire) begin
                rd_ptr <= ptr_add(rd_ptr, 2'd1);
            end
            count <= count + CW'(n_wr) - CW'(rd_fire);
        end
    end

endmodule

// File: rtl/prefetch_unit.sv
// rtl/prefetch_unit.sv - instruction prefetcher feeding a byte queue from cs:ip
//   clk, reset              : clock, asynchronous active-high reset
//   cs, new_ip, load_new_ip : code segment, jump target, flush/restart pulse
//   stall                   : block new fetches
//   instr_m_addr/access     : registered word request to the arbiter
//   instr_m_data_in/ack     : returned word and completion strobe
//   q_data, q_valid, q_rd_en: head byte, non-empty flag, pop
module prefetch_unit
    import prefetch_pkg::*;
#(
    parameter int QUEUE_DEPTH = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cs,
    input  logic [15:0] new_ip,
    input  logic        load_new_ip,
    input  logic        stall,
    output logic [18:0] instr_m_addr,
    input  logic [15:0] instr_m_data_in,
    output logic        instr_m_access,
    input  logic        instr_m_ack,
    output logic [7:0]  q_data,
    output logic        q_valid,
    input  logic        q_rd_en
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    prefetch_state_t state;
    logic [15:0]     fetch_ip;
    logic            req_odd;      // parity of the offset of the request in flight
    logic [CW-1:0]   fifo_count;
    logic            ack_take;
    logic [1:0]      wr_en;
    logic            pop;
    logic [CW:0]     occ_after;
    logic [CW:0]     free_after;
    logic            can_start;
    logic [15:0]     next_ip;
    logic [19:0]     next_phys;

    // Only a live FETCH consumes ack data; a flush in the same cycle drops it.
    assign ack_take  = (state == FETCH) && instr_m_ack && !load_new_ip;
    assign wr_en     = ack_take ? (req_odd ? 2'b10 : 2'b11) : 2'b00;
    assign pop       = q_rd_en && q_valid;

    // Occupancy as it will be after this edge, so the next request is only
    // issued when two bytes of room are guaranteed.
    always_comb begin
        occ_after = '0;
        if (!load_new_ip) begin
            occ_after = {1'b0, fifo_count} + (CW + 1)'(wr_en[0]) + (CW + 1)'(wr_en[1])
                        - (CW + 1)'(pop);
        end
    end

    assign free_after = (CW + 1)'(QUEUE_DEPTH) - occ_after;
    assign can_start  = !stall && (free_after >= (CW + 1)'(2));

    always_comb begin
        next_ip = fetch_ip;
        if (load_new_ip) begin
            next_ip = new_ip;
        end else if (ack_take) begin
            next_ip = fetch_ip + (req_odd ? 16'd1 : 16'd2);
        end
    end

    assign next_phys = phys_addr(cs, next_ip);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            fetch_ip       <= 16'h0000;
            req_odd        <= 1'b0;
            instr_m_access <= 1'b0;
            instr_m_addr   <= '0;
        end else begin
            fetch_ip <= next_ip;
            case (state)
                IDLE: begin
                    if (can_start) begin
                        state          <= FETCH;
                        instr_m_access <= 1'b1;
                        instr_m_addr   <= next_phys[19:1];
                        req_odd        <= next_phys[0];
                    end
                end
                FETCH: begin
                    if (instr_m_ack) begin
                        if (!load_new_ip && can_start) begin
                            instr_m_addr <= next_phys[19:1];
                            req_odd      <= next_phys[0];
                        end else begin
                            state          <= IDLE;
                            instr_m_access <= 1'b0;
                        end
                    end else if (load_new_ip) begin
                        // Request must stay asserted with its original address.
                        state <= ABORT;
                    end
                end
                ABORT: begin
                    if (instr_m_ack) begin
                        state          <= IDLE;
                        instr_m_access <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    instr_m_access <= 1'b0;
                end
            endcase
        end
    end

    prefetch_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (instr_m_data_in),
        .rd_en   (q_rd_en),
        .flush   (load_new_ip),
        .rd_data (q_data),
        .count   (fifo_count)
    );

    assign q_valid = (fifo_count != '0);

endmodule

// File: tb/tb_prefetch_unit.sv
// tb/tb_prefetch_unit.sv - self-checking bench for prefetch_unit
module tb_prefetch_unit;

    logic        clk;
    logic        reset;
    logic [15:0] cs;
    logic [15:0] new_ip;
    logic        load_new_ip;
    logic        stall;
    logic [18:0] instr_m_addr;
    logic [15:0] instr_m_data_in;
    logic        instr_m_access;
    logic        instr_m_ack;
    logic [7:0]  q_data;
    logic        q_valid;
    logic        q_rd_en;

    logic        man_ack;
    logic [15:0] man_data;
    logic        rsp_ack;
    logic [15:0] rsp_data;
    logic        resp_en;
    int          resp_delay;
    int          n_acks;

    int checks;
    int failures;

    assign instr_m_ack     = rsp_ack | man_ack;
    assign instr_m_data_in = resp_en ? rsp_data : man_data;

    prefetch_unit #(.QUEUE_DEPTH(6)) dut (
        .clk             (clk),
        .reset           (reset),
        .cs              (cs),
        .new_ip          (new_ip),
        .load_new_ip     (load_new_ip),
        .stall           (stall),
        .instr_m_addr    (instr_m_addr),
        .instr_m_data_in (instr_m_data_in),
        .instr_m_access  (instr_m_access),
        .instr_m_ack     (instr_m_ack),
        .q_data          (q_data),
        .q_valid         (q_valid),
        .q_rd_en         (q_rd_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] mem_byte(input logic [19:0] a);
        return a[7:0] ^ {a[19:16], a[11:8]};
    endfunction

    function automatic logic [15:0] mem_word(input logic [18:0] w);
        return {mem_byte({w, 1'b1}), mem_byte({w, 1'b0})};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [15:0] c, input logic st);
        resp_en     = 1'b0;
        man_ack     = 1'b0;
        load_new_ip = 1'b0;
        q_rd_en     = 1'b0;
        new_ip      = 16'h0000;
        stall       = st;
        cs          = c;
        reset       = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_access(input string name);
        int n;
        n = 0;
        while (!instr_m_access && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(instr_m_access), 32'd1);
    endtask

    // Memory responder: acks each request after resp_delay extra cycles.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        rsp_ack  = 1'b0;
        rsp_data = 16'h0000;
        n_acks   = 0;
        forever begin
            @(negedge clk);
            if (rsp_ack) wait_cnt = 0;
            rsp_ack = 1'b0;
            if (resp_en && instr_m_access && !reset) begin
                if (wait_cnt >= resp_delay) begin
                    rsp_ack  = 1'b1;
                    rsp_data = mem_word(instr_m_addr);
                    n_acks++;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    typedef struct {
        logic [15:0] cs;
        logic [15:0] ip;
        logic [18:0] addr;
        logic [18:0] next_addr;
        int          n;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] exp6[6];
        int base;
        int got;
        int cyc;

        checks     = 0;
        failures   = 0;
        resp_delay = 0;

        vecs[0] = '{16'h1000, 16'h0013, 19'h08009, 19'h0800A, 1, 8'h03, 8'h00};
        vecs[1] = '{16'h0000, 16'hFFFE, 19'h07FFF, 19'h00000, 2, 8'hF1, 8'hF0};
        vecs[2] = '{16'hFFFF, 16'h0000, 19'h7FFF8, 19'h7FFF9, 2, 8'h0F, 8'h0E};
        vecs[3] = '{16'hFFFF, 16'h0011, 19'h00000, 19'h00001, 1, 8'h01, 8'h00};
        vecs[4] = '{16'h1234, 16'h5678, 19'h0BCDC, 19'h0BCDD, 2, 8'hA1, 8'hA0};
        vecs[5] = '{16'h0000, 16'hFFFF, 19'h07FFF, 19'h00000, 1, 8'hF0, 8'h00};

        // Reset state
        do_reset(16'h0000, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_access", 32'(instr_m_access), 32'd0);
        check("rst_q_valid", 32'(q_valid), 32'd0);
        check("rst_q_data", 32'(q_data), 32'd0);

        // Table: flush-to-request latency, address formation, odd/even push, wrap
        for (int i = 0; i < 6; i++) begin
            do_reset(vecs[i].cs, 1'b1);
            @(negedge clk);
            check($sformatf("v%0d_stall_idle", i), 32'(instr_m_access), 32'd0);
            load_new_ip = 1'b1;
            new_ip      = vecs[i].ip;
            stall       = 1'b0;
            @(negedge clk);
            load_new_ip = 1'b0;
            check($sformatf("v%0d_access", i), 32'(instr_m_access), 32'd1);
            check($sformatf("v%0d_addr", i), 32'(instr_m_addr), 32'(vecs[i].addr));
            man_data = mem_word(instr_m_addr);
            man_ack  = 1'b1;
            @(negedge clk);
            man_ack = 1'b0;
            check($sformatf("v%0d_q_valid", i), 32'(q_valid), 32'd1);
            check($sformatf("v%0d_b0", i), 32'(q_data), 32'(vecs[i].b0));
            check($sformatf("v%0d_b2b_access", i), 32'(instr_m_access), 32'd1);
            check($sformatf("v%0d_next_addr", i), 32'(instr_m_addr), 32'(vecs[i].next_addr));
            q_rd_en = 1'b1;
            @(negedge clk);
            q_rd_en = 1'b0;
            check($sformatf("v%0d_valid_after_pop", i), 32'(q_valid), 32'(vecs[i].n == 2));
            if (vecs[i].n == 2) begin
                check($sformatf("v%0d_b1", i), 32'(q_data), 32'(vecs[i].b1));
            end
        end

        // cs=0xFFFF, 2-cycle ack, no pops: three words then stop
        do_reset(16'hFFFF, 1'b0);
        base       = n_acks;
        resp_delay = 2;
        resp_en    = 1'b1;
        wait_access("fill_first_access");
        check("fill_first_addr", 32'(instr_m_addr), 32'h7FFF8);
        repeat (40) @(negedge clk);
        check("fill_num_fetches", 32'(n_acks - base), 32'd3);
        check("fill_no_4th_access", 32'(instr_m_access), 32'd0);
        exp6 = '{8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A};
        q_rd_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("fill_valid%0d", k), 32'(q_valid), 32'd1);
            check($sformatf("fill_byte%0d", k), 32'(q_data), 32'(exp6[k]));
            @(negedge clk);
        end
        q_rd_en = 1'b0;

        // Flush while a fetch is outstanding; ack arrives 3 cycles later
        do_reset(16'h0000, 1'b0);
        wait_access("abort_access");
        load_new_ip = 1'b1;
        new_ip      = 16'h0200;
        @(negedge clk);
        load_new_ip = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("abort_hold_access%0d", k), 32'(instr_m_access), 32'd1);
            check($sformatf("abort_hold_addr%0d", k), 32'(instr_m_addr), 32'h00000);
            if (k < 2) @(negedge clk);
        end
        man_data = 16'hBEEF;
        man_ack  = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        check("abort_access_drop", 32'(instr_m_access), 32'd0);
        check("abort_no_push", 32'(q_valid), 32'd0);
        @(negedge clk);
        check("abort_restart_access", 32'(instr_m_access), 32'd1);
        check("abort_restart_addr", 32'(instr_m_addr), 32'h00100);
        check("abort_still_empty", 32'(q_valid), 32'd0);

        // Flush coincident with ack and pop
        do_reset(16'h0000, 1'b0);
        wait_access("coinc_access");
        man_data = mem_word(instr_m_addr);
        man_ack  = 1'b1;
        @(negedge clk);
        check("coinc_q_valid_before", 32'(q_valid), 32'd1);
        man_data    = 16'hDEAD;
        load_new_ip = 1'b1;
        new_ip      = 16'h0040;
        q_rd_en     = 1'b1;
        @(negedge clk);
        man_ack     = 1'b0;
        load_new_ip = 1'b0;
        q_rd_en     = 1'b0;
        check("coinc_q_empty", 32'(q_valid), 32'd0);
        check("coinc_access_low", 32'(instr_m_access), 32'd0);
        @(negedge clk);
        check("coinc_new_access", 32'(instr_m_access), 32'd1);
        check("coinc_new_addr", 32'(instr_m_addr), 32'h00020);
        check("coinc_still_empty", 32'(q_valid), 32'd0);

        // Reset asserted mid-fetch with an ack pending
        do_reset(16'h0000, 1'b0);
        wait_access("rstmid_access");
        reset    = 1'b1;
        man_data = 16'h1234;
        man_ack  = 1'b1;
        @(negedge clk);
        check("rstmid_access_clear", 32'(instr_m_access), 32'd0);
        check("rstmid_q_empty", 32'(q_valid), 32'd0);
        man_ack = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        check("rstmid_restart_addr", 32'(instr_m_addr), 32'h00000);
        check("rstmid_q_empty_after", 32'(q_valid), 32'd0);

        // Continuous pops with single-cycle ack: contiguous byte stream
        do_reset(16'h2000, 1'b0);
        resp_delay = 0;
        resp_en    = 1'b1;
        q_rd_en    = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 32 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (q_valid) begin
                check($sformatf("stream_byte%0d", got), 32'(q_data),
                      32'(mem_byte(20'h20000 + 20'(got))));
                got++;
            end
        end
        check("stream_count", 32'(got), 32'd32);
        q_rd_en = 1'b0;
        resp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
